// File: rtl/rv32i_data_ram.sv
// Byte-addressable data RAM for the single-cycle RV32I core: lane-masked stores on
// the clock edge, combinational extended loads, sticky store faults and a store counter.
module rv32i_data_ram #(
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iData_WrEn,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iData_Addr,
    input  logic [31:0] iData_WrData,
    input  logic        iFault_Clr,
    output logic [31:0] oData_RdData,
    output logic [2:0]  oFault,
    output logic [15:0] oStore_Cnt
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteOff;
    logic              inRange;
    logic              stIllegal;
    logic              stMisaligned;
    logic              stCommit;
    logic [2:0]        newFault;
    logic [3:0]        laneMask;
    logic [31:0]       laneData;
    logic [31:0]       rdWord;
    logic [7:0]        rdByte;
    logic [15:0]       rdHalf;
    logic [15:0]       storeCnt;
    logic [2:0]        faultReg;

    assign wordIdx = iData_Addr[ADDR_W+1:2];
    assign byteOff = iData_Addr[1:0];
    // Compare every upper bit so out-of-range addresses never alias onto real words.
    assign inRange = (iData_Addr[31:ADDR_W+2] == '0);

    always_comb begin
        stIllegal    = 1'b0;
        stMisaligned = 1'b0;
        laneMask     = 4'b0000;
        laneData     = '0;
        case (iFunct3)
            3'b000: begin
                laneMask = 4'b0001 << byteOff;
                laneData = {4{iData_WrData[7:0]}};
            end
            3'b001: begin
                stMisaligned = byteOff[0];
                laneMask     = byteOff[1] ? 4'b1100 : 4'b0011;
                laneData     = {2{iData_WrData[15:0]}};
            end
            3'b010: begin
                stMisaligned = (byteOff != 2'b00);
                laneMask     = 4'b1111;
                laneData     = iData_WrData;
            end
            default: stIllegal = 1'b1;
        endcase

        // Only the highest-priority failing check is reported.
        newFault = 3'b000;
        if (iData_WrEn) begin
            if (stIllegal)
                newFault = 3'b100;
            else if (!inRange)
                newFault = 3'b010;
            else if (stMisaligned)
                newFault = 3'b001;
        end
        stCommit = iData_WrEn && (newFault == 3'b000);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (stCommit) begin
            for (int l = 0; l < 4; l++)
                if (laneMask[l])
                    mem[wordIdx][8*l +: 8] <= laneData[8*l +: 8];
        end
    end

    // A fault raised in the same cycle as a clear survives the clear.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            storeCnt <= '0;
            faultReg <= '0;
        end else begin
            if (stCommit && storeCnt != 16'hFFFF)
                storeCnt <= storeCnt + 16'd1;
            if (iFault_Clr)
                faultReg <= newFault;
            else
                faultReg <= faultReg | newFault;
        end
    end

    always_comb begin
        rdWord = mem[wordIdx];
        case (byteOff)
            2'b00:   rdByte = rdWord[7:0];
            2'b01:   rdByte = rdWord[15:8];
            2'b10:   rdByte = rdWord[23:16];
            default: rdByte = rdWord[31:24];
        endcase
        rdHalf = byteOff[1] ? rdWord[31:16] : rdWord[15:0];

        oData_RdData = '0;
        if (inRange) begin
            case (iFunct3)
                3'b000: oData_RdData = {{24{rdByte[7]}}, rdByte};
                3'b001: if (!byteOff[0]) oData_RdData = {{16{rdHalf[15]}}, rdHalf};
                3'b010: if (byteOff == 2'b00) oData_RdData = rdWord;
                3'b100: oData_RdData = {24'd0, rdByte};
                3'b101: if (!byteOff[0]) oData_RdData = {16'd0, rdHalf};
                default: oData_RdData = '0;
            endcase
        end
    end

    assign oFault     = faultReg;
    assign oStore_Cnt = storeCnt;

endmodule

// File: tb/tb_rv32i_data_ram.sv
// Directed self-checking bench for rv32i_data_ram with hand-computed expectations.
module tb_rv32i_data_ram;

    logic        iClk;
    logic        iRst;
    logic        iData_WrEn;
    logic [2:0]  iFunct3;
    logic [31:0] iData_Addr;
    logic [31:0] iData_WrData;
    logic        iFault_Clr;
    logic [31:0] oData_RdData;
    logic [2:0]  oFault;
    logic [15:0] oStore_Cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    rv32i_data_ram #(.DEPTH(64)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iData_WrEn(iData_WrEn),
        .iFunct3(iFunct3),
        .iData_Addr(iData_Addr),
        .iData_WrData(iData_WrData),
        .iFault_Clr(iFault_Clr),
        .oData_RdData(oData_RdData),
        .oFault(oFault),
        .oStore_Cnt(oStore_Cnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic applyStimulus(input logic wrEn, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic clr);
        iData_WrEn   = wrEn;
        iFunct3      = f3;
        iData_Addr   = addr;
        iData_WrData = data;
        iFault_Clr   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one store, let it commit on the next edge, then return to idle.
    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic clr);
        applyStimulus(1'b1, f3, addr, data, clr);
        @(posedge iClk);
        #1;
        applyStimulus(1'b0, F_W, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic checkLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] expected);
        applyStimulus(1'b0, f3, addr, 32'h0, 1'b0);
        #1;
        checkOutput(tag, oData_RdData, expected);
    endtask

    initial begin
        iRst = 1'b0;
        applyStimulus(1'b0, F_W, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        #1;

        // Reset state
        checkLoad("rst_lw00", F_W, 32'h00, 32'h0);
        checkLoad("rst_lw04", F_W, 32'h04, 32'h0);
        checkLoad("rst_lwFC", F_W, 32'hFC, 32'h0);
        checkOutput("rst_fault", {29'd0, oFault}, 32'h0);
        checkOutput("rst_cnt", {16'd0, oStore_Cnt}, 32'h0);

        // Word store and extended loads
        doStore(F_W, 32'h10, 32'h8081_F27F, 1'b0);
        checkLoad("lw10", F_W, 32'h10, 32'h8081F27F);
        checkLoad("lb10", F_B, 32'h10, 32'h0000007F);
        checkLoad("lb11", F_B, 32'h11, 32'hFFFFFFF2);
        checkLoad("lbu13", F_BU, 32'h13, 32'h00000080);
        checkLoad("lh12", F_H, 32'h12, 32'hFFFF8081);
        checkLoad("lhu10", F_HU, 32'h10, 32'h0000F27F);
        checkOutput("cnt_1", {16'd0, oStore_Cnt}, 32'd1);

        // Sub-word stores
        doStore(F_B, 32'h12, 32'hFFFF_FFAA, 1'b0);
        checkLoad("sb12", F_W, 32'h10, 32'h80AAF27F);
        doStore(F_H, 32'h10, 32'hFFFF_1234, 1'b0);
        checkLoad("sh10", F_W, 32'h10, 32'h80AA1234);
        checkOutput("cnt_3", {16'd0, oStore_Cnt}, 32'd3);

        // Load-side zero returns
        checkLoad("lw_oor_alias", F_W, 32'h110, 32'h0);
        checkLoad("lw_misal", F_W, 32'h12, 32'h0);
        checkLoad("lh_misal", F_H, 32'h11, 32'h0);
        checkLoad("ld_f3_011", 3'b011, 32'h10, 32'h0);
        checkLoad("lb_oor", F_B, 32'h100, 32'h0);

        // Store faults
        doStore(F_W, 32'h11, 32'hDEAD_BEEF, 1'b0);
        checkOutput("flt_misal", {29'd0, oFault}, 32'b001);
        checkLoad("flt_misal_word", F_W, 32'h10, 32'h80AA1234);
        checkOutput("flt_misal_cnt", {16'd0, oStore_Cnt}, 32'd3);
        doStore(F_W, 32'h100, 32'hDEAD_BEEF, 1'b0);
        checkOutput("flt_oor", {29'd0, oFault}, 32'b011);
        checkLoad("flt_oor_noalias", F_W, 32'h00, 32'h0);
        doStore(3'b011, 32'h10, 32'hDEAD_BEEF, 1'b0);
        checkOutput("flt_illegal", {29'd0, oFault}, 32'b111);
        checkLoad("flt_ill_word", F_W, 32'h10, 32'h80AA1234);
        doStore(F_H, 32'h01, 32'hDEAD_BEEF, 1'b1);
        checkOutput("flt_clr_new", {29'd0, oFault}, 32'b001);
        doStore(3'b110, 32'h200, 32'h0, 1'b0);
        checkOutput("flt_ill_prio", {29'd0, oFault}, 32'b101);
        applyStimulus(1'b0, F_W, 32'h0, 32'h0, 1'b1);
        @(posedge iClk);
        #1;
        applyStimulus(1'b0, F_W, 32'h0, 32'h0, 1'b0);
        checkOutput("flt_clr", {29'd0, oFault}, 32'b000);
        checkOutput("flt_cnt", {16'd0, oStore_Cnt}, 32'd3);

        // Read-during-write shows old data, new data on the next cycle
        applyStimulus(1'b1, F_W, 32'h20, 32'h1111_1111, 1'b0);
        #1;
        checkOutput("rdw_old", oData_RdData, 32'h0);
        @(posedge iClk);
        #1;
        applyStimulus(1'b0, F_W, 32'h20, 32'h0, 1'b0);
        #1;
        checkOutput("rdw_new", oData_RdData, 32'h1111_1111);

        // Last word in range
        doStore(F_W, 32'hFC, 32'hCAFE_0123, 1'b0);
        checkLoad("lwFC", F_W, 32'hFC, 32'hCAFE_0123);
        checkLoad("lbFF", F_B, 32'hFF, 32'hFFFFFFCA);
        checkOutput("cnt_5", {16'd0, oStore_Cnt}, 32'd5);

        // Asynchronous reset between edges
        doStore(F_W, 32'h13, 32'h0, 1'b0);
        checkOutput("pre_rst_fault", {29'd0, oFault}, 32'b001);
        applyStimulus(1'b0, F_W, 32'h10, 32'h0, 1'b0);
        #2;
        iRst = 1'b0;
        #1;
        checkOutput("arst_lw10", oData_RdData, 32'h0);
        checkOutput("arst_fault", {29'd0, oFault}, 32'h0);
        checkOutput("arst_cnt", {16'd0, oStore_Cnt}, 32'h0);
        iData_Addr = 32'hFC;
        #1;
        checkOutput("arst_lwFC", oData_RdData, 32'h0);
        @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        #1;

        // Counter saturation
        for (int i = 0; i < 65534; i++)
            doStore(F_B, 32'h04, i, 1'b0);
        checkOutput("cnt_fffe", {16'd0, oStore_Cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++)
            doStore(F_W, 32'h08, 32'hA5A5_0000 + i, 1'b0);
        checkOutput("cnt_sat", {16'd0, oStore_Cnt}, 32'h0000FFFF);
        checkLoad("sat_lw08", F_W, 32'h08, 32'hA5A5_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
